scg_cmd_sched: RTL
==================

Name: scg_cmd_sched

Overview:
- Command scheduler that drives the 3-bit opcode input of the burst-mode opcode FSM.
- Arbitrates host read and write requests against periodic auto-refresh and against self-refresh (sleep) entry and exit.
- Issues at most one opcode per FSM READY period, then tracks completion through the FSM's idle output.
- Sits between the host-side request logic and the opcode FSM in the SDRAM controller.

Parameters:
- REF_INTERVAL, 780: clock cycles between refresh ticks.
- MAX_PEND, 4: postponed-refresh limit; at this value refresh becomes urgent.
- CNT_W, 10: refresh timer width; must satisfy 2^CNT_W > REF_INTERVAL.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset. One clock; reset is asynchronous and active-low.
- fsm_idle  in  1  opcode FSM idle (FSM in READY).
- rd_req  in  1  host read request, level, held until rd_ack.
- rd_burst  in  1  read type: 1 = burst (opcode 5), 0 = non-burst (opcode 4).
- wr_req  in  1  host write request, level, held until wr_ack.
- wr_burst  in  1  write type: 1 = burst (opcode 7), 0 = non-burst (opcode 6).
- sleep_req  in  1  self-refresh request, level.
- opcode  out  3  opcode to the FSM.
- rd_ack  out  1  one-cycle pulse when a read opcode is issued.
- wr_ack  out  1  one-cycle pulse when a write opcode is issued.
- asleep  out  1  high while in self-refresh.
- busy  out  1  high in every state except ARB.
- ref_err  out  1  sticky refresh-overrun flag; clears only on reset.

Behaviour:
- Reset values:
  - state = INIT_WAIT; opcode = 0; rd_ack, wr_ack, asleep, ref_err = 0; busy = 1.
  - Refresh timer = 0; pend = 0.
- Opcode encoding:
  - 0 = none / self-refresh exit.
  - 1 = hold; the FSM ignores it in READY.
  - 2 = self-refresh; 3 = auto-refresh.
  - 4 / 5 = read non-burst / burst; 6 / 7 = write non-burst / burst.
- opcode is registered. It is nonzero only in ISSUE (the command code) and in SLEEP (value 1).
- Refresh timer:
  - Counts every cycle except in SLEEP and WAKE.
  - At REF_INTERVAL-1 it wraps to 0 and produces a tick.
  - Tick increments pend, which saturates at MAX_PEND.
  - A tick while pend == MAX_PEND sets ref_err.
  - Issuing opcode 3 decrements pend. Tick and issue in the same cycle leave pend unchanged.
  - Entering SLEEP clears both timer and pend.
- State machine:
  - INIT_WAIT: wait for fsm_idle = 1 (FSM init complete), then go to ARB.
  - ARB: taken only when fsm_idle = 1; otherwise stay. Priority order:
    1. pend == MAX_PEND: refresh (3).
    2. sleep_req: self-refresh (2).
    3. rd_req / wr_req: round-robin. A last-granted flag starts at write, so the first read wins a tie.
    4. pend > 0: refresh (3).
    5. Otherwise stay in ARB.
  - On selection, latch the code into opcode and go to ISSUE next cycle.
  - ISSUE (exactly 1 cycle):
    - opcode carries the code and the FSM samples it.
    - rd_ack / wr_ack pulse for host commands.
    - The pend decrement happens for refresh.
    - Next state is SLEEP if the code was 2, otherwise BUSY; opcode goes to 0 (BUSY) or 1 (SLEEP).
  - BUSY: wait for fsm_idle = 1, then go to ARB. fsm_idle is guaranteed 0 on the first BUSY cycle.
  - SLEEP:
    - asleep = 1, opcode = 1.
    - When sleep_req = 0, set opcode = 0 and go to WAKE.
    - The FSM leaves self-refresh only after opcode 0, so opcode 1 holds it there.
  - WAKE: opcode = 0, asleep = 0; wait for fsm_idle = 1, then go to ARB.
- Latency: a request present in ARB with fsm_idle = 1 is acked 1 cycle later, and the FSM leaves READY 2 cycles after ARB.
- Boundary cases:
  - rd_req and wr_req dropped in the same cycle as ARB selection: not permitted (host must hold until ack).
  - sleep_req pulse shorter than the self-refresh entry: WAKE still waits for idle.
  - Reset mid-command: all state returns to reset values and the FSM reinitialises in parallel.

Decomposition:
- Package scg_pkg holds:
  - The OpcodeType enum (NONE = 0, HOLD = 1, SELF_REF = 2, AUTO_REF = 3, READ_NB = 4, READ_BRST = 5, WRITE_NB = 6, WRITE_BRST = 7), shared with the opcode FSM.
  - The SchedState enum.
- Sub-module scg_ref_timer holds the refresh timer and pending counter, with ports: tick, issue, clear, pend, urgent, overrun.

Test Plan:
- Reset, then fsm_idle = 0 for 50 cycles, then 1 → opcode stays 0 until idle. After idle, with no requests, state ARB and busy = 0.
- rd_req = 1, rd_burst = 1 in ARB → next cycle opcode = 5 and rd_ack = 1 for exactly 1 cycle. Then opcode = 0 and busy = 1 until fsm_idle returns.
- rd_req and wr_req both held, wr_burst = 0, across 4 grants → grant order is opcodes 4, 6, 4, 6 (with rd_burst = 0).
- Hold fsm_idle = 0 for 5×REF_INTERVAL cycles → pend saturates at 4 and ref_err = 1. Next ARB issues opcode 3 ahead of a pending wr_req.
- sleep_req = 1 → opcode 2 for 1 cycle, then 1 with asleep = 1. Drop sleep_req → opcode 0 next cycle, then ARB after fsm_idle; pend = 0 throughout.
- Assert n_rst low during BUSY → all outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/scg_pkg.sv
// Shared types for the SDRAM command scheduler and the burst-mode opcode FSM.
package scg_pkg;

  typedef enum logic [2:0] {
    NONE       = 3'd0,
    HOLD       = 3'd1,
    SELF_REF   = 3'd2,
    AUTO_REF   = 3'd3,
    READ_NB    = 3'd4,
    READ_BRST  = 3'd5,
    WRITE_NB   = 3'd6,
    WRITE_BRST = 3'd7
  } opcode_type_e;

  typedef enum logic [2:0] {
    StInitWait = 3'd0,
    StArb      = 3'd1,
    StIssue    = 3'd2,
    StBusy     = 3'd3,
    StSleep    = 3'd4,
    StWake     = 3'd5
  } sched_state_e;

endpackage

// File: rtl/scg_ref_timer.sv
// Auto-refresh interval timer and postponed-refresh counter.
module scg_ref_timer #(
  parameter int unsigned REF_INTERVAL = 780,
  parameter int unsigned MAX_PEND     = 4,
  parameter int unsigned CNT_W        = 10,
  parameter int unsigned PEND_W       = $clog2(MAX_PEND + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              issue,
  input  logic              clear,
  output logic              tick,
  output logic [PEND_W-1:0] pend,
  output logic              urgent,
  output logic              overrun
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              overrun_q, overrun_d;

  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q + 1'b1;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(REF_INTERVAL - 1)) begin
      cnt_d = '0;
      tick  = 1'b1;
    end
  end

  assign urgent = (pend_q == PEND_W'(MAX_PEND));

  // A tick and an issued refresh in the same cycle cancel out.
  always_comb begin
    pend_d    = pend_q;
    overrun_d = overrun_q | (tick & urgent);
    if (clear) begin
      pend_d = '0;
    end else if (tick && !issue && !urgent) begin
      pend_d = pend_q + 1'b1;
    end else if (issue && !tick && (pend_q != '0)) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q     <= '0;
      pend_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
    end
  end

  assign pend    = pend_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/scg_cmd_sched.sv
// Command scheduler: arbitrates host reads/writes, auto-refresh and self-refresh
// into one registered opcode per FSM READY period.
module scg_cmd_sched
  import scg_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = 780,
  parameter int unsigned MAX_PEND     = 4,
  parameter int unsigned CNT_W        = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       fsm_idle,
  input  logic       rd_req,
  input  logic       rd_burst,
  input  logic       wr_req,
  input  logic       wr_burst,
  input  logic       sleep_req,
  output logic [2:0] opcode,
  output logic       rd_ack,
  output logic       wr_ack,
  output logic       asleep,
  output logic       busy,
  output logic       ref_err
);

  localparam int unsigned PEND_W = $clog2(MAX_PEND + 1);

  sched_state_e      state_q, state_d;
  opcode_type_e      opcode_q, opcode_d, sel_code;
  logic              sel_valid, sel_rd, sel_wr;
  logic              rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d;
  logic              last_wr_q, last_wr_d;
  logic              ref_tick, ref_issue, ref_clear, ref_urgent, ref_overrun;
  logic [PEND_W-1:0] pend;
  logic              unused_ref_tick;

  assign unused_ref_tick = ref_tick;

  scg_ref_timer #(
    .REF_INTERVAL(REF_INTERVAL),
    .MAX_PEND    (MAX_PEND),
    .CNT_W       (CNT_W),
    .PEND_W      (PEND_W)
  ) u_ref_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .issue  (ref_issue),
    .clear  (ref_clear),
    .tick   (ref_tick),
    .pend   (pend),
    .urgent (ref_urgent),
    .overrun(ref_overrun)
  );

  // Read wins a read/write tie unless it was the last host grant.
  always_comb begin
    sel_valid = 1'b1;
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    sel_code  = NONE;
    if (ref_urgent) begin
      sel_code = AUTO_REF;
    end else if (sleep_req) begin
      sel_code = SELF_REF;
    end else if (rd_req && (!wr_req || last_wr_q)) begin
      sel_code = rd_burst ? READ_BRST : READ_NB;
      sel_rd   = 1'b1;
    end else if (wr_req) begin
      sel_code = wr_burst ? WRITE_BRST : WRITE_NB;
      sel_wr   = 1'b1;
    end else if (pend != '0) begin
      sel_code = AUTO_REF;
    end else begin
      sel_valid = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    rd_ack_d  = 1'b0;
    wr_ack_d  = 1'b0;
    last_wr_d = last_wr_q;
    unique case (state_q)
      StInitWait: if (fsm_idle) state_d = StArb;
      StArb: begin
        if (fsm_idle && sel_valid) begin
          state_d  = StIssue;
          opcode_d = sel_code;
          rd_ack_d = sel_rd;
          wr_ack_d = sel_wr;
          if (sel_rd) last_wr_d = 1'b0;
          if (sel_wr) last_wr_d = 1'b1;
        end
      end
      StIssue: begin
        if (opcode_q == SELF_REF) begin
          state_d  = StSleep;
          opcode_d = HOLD;
        end else begin
          state_d  = StBusy;
          opcode_d = NONE;
        end
      end
      StBusy: if (fsm_idle) state_d = StArb;
      // HOLD keeps the FSM in self-refresh; NONE releases it.
      StSleep: begin
        if (!sleep_req) begin
          state_d  = StWake;
          opcode_d = NONE;
        end
      end
      StWake: if (fsm_idle) state_d = StArb;
      default: begin
        state_d  = StInitWait;
        opcode_d = NONE;
      end
    endcase
  end

  assign ref_issue = (state_q == StIssue) && (opcode_q == AUTO_REF);
  assign ref_clear = (state_q == StSleep) || (state_q == StWake) ||
                     ((state_q == StIssue) && (opcode_q == SELF_REF));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StInitWait;
      opcode_q  <= NONE;
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      last_wr_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      rd_ack_q  <= rd_ack_d;
      wr_ack_q  <= wr_ack_d;
      last_wr_q <= last_wr_d;
    end
  end

  assign opcode  = opcode_q;
  assign rd_ack  = rd_ack_q;
  assign wr_ack  = wr_ack_q;
  assign asleep  = (state_q == StSleep);
  assign busy    = (state_q != StArb);
  assign ref_err = ref_overrun;

endmodule
